// File: rtl/led_cmd_engine_if.sv
// Byte-in / LED-out bundle between the UART receiver side and the LED command engine.
interface led_cmd_engine_if #(parameter int NUM_LEDS = 10);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [NUM_LEDS-1:0] led_out;
  logic [1:0]          mode;
  logic                busy;
  logic                cmd_err;
  logic [7:0]          last_cmd;

  modport master (output rx_data, rx_valid,
                  input  led_out, mode, busy, cmd_err, last_cmd);
  modport slave  (input  rx_data, rx_valid,
                  output led_out, mode, busy, cmd_err, last_cmd);
endinterface

// File: rtl/led_cmd_engine.sv
// UART byte command parser driving NUM_LEDS LEDs in static, blink or rotate mode.
// Two-byte commands wait in ARG with a timeout; timing comes from a free-running prescaler.
module led_cmd_engine #(
  parameter int NUM_LEDS    = 10,
  parameter int TICK_DIV    = 5_000_000,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  led_cmd_engine_if.slave  bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [31:0]         U32   = 32'h5555_5555;
  localparam logic [NUM_LEDS-1:0] U_PAT = U32[NUM_LEDS-1:0];
  localparam logic [1:0] M_STATIC = 2'b00, M_BLINK = 2'b01, M_ROT = 2'b10;

  typedef enum logic {IDLE, ARG} state_e;

  state_e              state_q, state_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d, led_q, led_d;
  logic [1:0]          mode_q, mode_d;
  logic [3:0]          rate_q, rate_d, step_q, step_d;
  logic                phase_q, phase_d, busy_q, busy_d, err_q, err_d;
  logic [7:0]          last_q, last_d, op_q, op_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [TW-1:0]       to_q, to_d;

  logic       tick, fire, pat_wr, clr_step, mode_wr, is_digit;
  logic [7:0] idx;
  logic [31:0] arg_ext;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    mode_d   = mode_q;
    rate_d   = rate_q;
    step_d   = step_q;
    phase_d  = phase_q;
    busy_d   = busy_q;
    err_d    = 1'b0;
    last_d   = last_q;
    op_d     = op_q;
    to_d     = to_q;
    fire     = 1'b0;
    pat_wr   = 1'b0;
    clr_step = 1'b0;
    mode_wr  = 1'b0;
    idx      = bus.rx_data - 8'h30;
    is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    arg_ext  = {24'd0, bus.rx_data};

    tick  = (pre_q == PW'(TICK_DIV - 1));
    pre_d = tick ? '0 : pre_q + 1'b1;

    // Mode step first; any command below overrides what it wrote.
    if (mode_q != M_STATIC && tick) begin
      if (step_q == rate_q) begin
        fire   = 1'b1;
        step_d = '0;
      end else begin
        step_d = step_q + 1'b1;
      end
    end
    if (fire && mode_q == M_BLINK) phase_d = ~phase_q;
    if (fire && mode_q == M_ROT)   pat_d   = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};

    case (state_q)
      IDLE: if (bus.rx_valid) begin
        last_d = bus.rx_data;
        case (bus.rx_data)
          8'h30: begin pat_d = '0;    pat_wr = 1'b1; end
          8'h31: begin pat_d = '1;    pat_wr = 1'b1; end
          8'h55: begin pat_d = U_PAT; pat_wr = 1'b1; end
          8'h53: begin mode_d = M_STATIC; mode_wr = 1'b1; end
          8'h4B: begin mode_d = M_BLINK;  mode_wr = 1'b1; end
          8'h52: begin mode_d = M_ROT;    mode_wr = 1'b1; end
          8'h54, 8'h50, 8'h44: begin
            state_d = ARG;
            op_d    = bus.rx_data;
            busy_d  = 1'b1;
            to_d    = '0;
          end
          default: err_d = 1'b1;
        endcase
      end
      ARG: if (bus.rx_valid) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        case (op_q)
          8'h54: if (is_digit && (32'(idx) < NUM_LEDS)) begin
                   pat_d  = pat_q ^ (NUM_LEDS'(1) << idx[4:0]);
                   pat_wr = 1'b1;
                 end else err_d = 1'b1;
          8'h50: begin pat_d = arg_ext[NUM_LEDS-1:0]; pat_wr = 1'b1; end
          8'h44: if (is_digit) begin
                   rate_d   = idx[3:0];
                   clr_step = 1'b1;
                 end else err_d = 1'b1;
          default: err_d = 1'b1;
        endcase
      end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        err_d   = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (pat_wr || clr_step || mode_wr) step_d = '0;
    if (mode_wr) phase_d = 1'b1;
    if (mode_d == M_STATIC) begin
      step_d  = '0;
      phase_d = 1'b1;
    end

    led_d = (mode_d == M_BLINK && !phase_d) ? '0 : pat_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      led_q   <= '0;
      mode_q  <= M_STATIC;
      rate_q  <= '0;
      step_q  <= '0;
      phase_q <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 8'h00;
      op_q    <= 8'h00;
      pre_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      led_q   <= led_d;
      mode_q  <= mode_d;
      rate_q  <= rate_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      last_q  <= last_d;
      op_q    <= op_d;
      pre_q   <= pre_d;
      to_q    <= to_d;
    end
  end

  assign bus.led_out  = led_q;
  assign bus.mode     = mode_q;
  assign bus.busy     = busy_q;
  assign bus.cmd_err  = err_q;
  assign bus.last_cmd = last_q;
endmodule

// File: tb/tb_led_cmd_engine.sv
// Directed bench for led_cmd_engine with NUM_LEDS=10, TICK_DIV=4, TIMEOUT_CYC=20.
module tb_led_cmd_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  led_cmd_engine_if #(.NUM_LEDS(10)) bus ();

  led_cmd_engine #(.NUM_LEDS(10), .TICK_DIV(4), .TIMEOUT_CYC(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte has been clocked in.
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_change(input logic [9:0] prev, output int cyc);
    cyc = 0;
    while (bus.led_out === prev && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  logic [9:0] rot_exp [4] = '{10'h102, 10'h204, 10'h009, 10'h012};
  logic [9:0] blk_exp [3] = '{10'h000, 10'h00F, 10'h000};
  logic [9:0] prev;
  int cyc;
  int chg;

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #12;
    chk("rst_led",  32'(bus.led_out), 32'h0);
    chk("rst_mode", 32'(bus.mode), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_err",  32'(bus.cmd_err), 32'h0);
    chk("rst_last", 32'(bus.last_cmd), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    send(8'h55);
    chk("U_led",  32'(bus.led_out), 32'h155);
    chk("U_err",  32'(bus.cmd_err), 32'h0);
    chk("U_last", 32'(bus.last_cmd), 32'h55);

    send(8'h30);
    send(8'h54);
    chk("T_busy", 32'(bus.busy), 32'h1);
    send(8'h33);
    chk("T3_busy", 32'(bus.busy), 32'h0);
    chk("T3_led",  32'(bus.led_out), 32'h008);
    send(8'h54); send(8'h39); send(8'h54); send(8'h39);
    chk("T9T9_led", 32'(bus.led_out), 32'h008);

    send(8'h54); send(8'h41);
    chk("TA_err",  32'(bus.cmd_err), 32'h1);
    chk("TA_led",  32'(bus.led_out), 32'h008);
    chk("TA_last", 32'(bus.last_cmd), 32'h54);
    idle(1);
    chk("err_pulse", 32'(bus.cmd_err), 32'h0);
    send(8'h58);
    chk("X_err",  32'(bus.cmd_err), 32'h1);
    chk("X_led",  32'(bus.led_out), 32'h008);
    chk("X_last", 32'(bus.last_cmd), 32'h58);

    send(8'h54);
    idle(19);
    chk("to19_err",  32'(bus.cmd_err), 32'h0);
    chk("to19_busy", 32'(bus.busy), 32'h1);
    idle(1);
    chk("to20_err",  32'(bus.cmd_err), 32'h1);
    chk("to20_busy", 32'(bus.busy), 32'h0);
    chk("to20_led",  32'(bus.led_out), 32'h008);
    send(8'h31);
    chk("one_led", 32'(bus.led_out), 32'h3FF);

    // Rotate at rate 1: a step every 8 clk, 0x204 -> 0x009 shows MSB wrap.
    send(8'h44); send(8'h31);
    send(8'h50); send(8'h81);
    chk("P81_led", 32'(bus.led_out), 32'h081);
    send(8'h52);
    chk("R_mode", 32'(bus.mode), 32'h2);
    chk("R_led",  32'(bus.led_out), 32'h081);
    for (int k = 0; k < 4; k++) begin
      prev = bus.led_out;
      wait_change(prev, cyc);
      chk($sformatf("rot%0d_led", k), 32'(bus.led_out), 32'(rot_exp[k]));
      if (k > 0) chk($sformatf("rot%0d_gap", k), 32'(cyc), 32'd8);
    end

    // Blink at rate 0: toggles every 4 clk.
    send(8'h53);
    send(8'h44); send(8'h30);
    send(8'h50); send(8'h0F);
    send(8'h4B);
    chk("K_mode", 32'(bus.mode), 32'h1);
    chk("K_led",  32'(bus.led_out), 32'h00F);
    for (int k = 0; k < 3; k++) begin
      prev = bus.led_out;
      wait_change(prev, cyc);
      chk($sformatf("blk%0d_led", k), 32'(bus.led_out), 32'(blk_exp[k]));
      if (k > 0) chk($sformatf("blk%0d_gap", k), 32'(cyc), 32'd4);
    end

    // Async reset mid-command.
    send(8'h54);
    chk("pre_rst_busy", 32'(bus.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led",  32'(bus.led_out), 32'h0);
    chk("arst_mode", 32'(bus.mode), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_last", 32'(bus.last_cmd), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h53);
    send(8'h31);
    chk("S_mode", 32'(bus.mode), 32'h0);
    chk("S_led",  32'(bus.led_out), 32'h3FF);
    chg = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.led_out !== 10'h3FF) chg++;
    end
    chk("S_hold", 32'(chg), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
